// File: rtl/sm_sat_accum_if.sv
// Handshake bundle for sm_sat_accum.
//   Input stream : in_valid/in_ready carry one sign-magnitude operand (in_data),
//                  an add/subtract select (in_sub) and an end-of-frame mark
//                  (in_last).
//   Output stream: out_valid/out_ready carry the frame result (out_data), the
//                  sticky saturation flag (out_sat) and the beat count
//                  (out_count).
// The accumulator uses the slave modport; whoever feeds it and takes its
// results uses the master modport.
interface sm_sat_accum_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_sub;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_sat;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/sm_sat_accum.sv
// Streaming sign-magnitude accumulator with saturation.
// A frame of operands arrives over the input handshake; each operand is added
// (or subtracted when in_sub is set) into a sign-magnitude accumulator whose
// every partial sum is clamped to +/-(2^(WIDTH-1)-1). When the in_last beat is
// accepted the block holds the result on the output handshake until it is
// taken, then returns to idle.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous, active-high reset
//   bus : sm_sat_accum_if slave modport (input stream + result stream)
module sm_sat_accum #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  sm_sat_accum_if.slave  bus
);

  localparam int M = WIDTH - 1;  // magnitude bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_n;
  logic               acc_sign, acc_sign_n;
  logic [M-1:0]       acc_mag, acc_mag_n;
  logic               sat, sat_n;
  logic [COUNT_W-1:0] count, count_n;
  logic               in_ready_q, in_ready_n;

  // Operand and adder signals
  logic               accept;
  logic [M-1:0]       op_mag;
  logic               op_sign;
  logic               base_sign;
  logic [M-1:0]       base_mag;
  logic [M:0]         sum;
  logic               add_sign;
  logic [M-1:0]       add_mag;
  logic               clamp;

  // Sign-magnitude add of the running value and the current operand.
  // A frame starts from +0, so in IDLE the running value is ignored.
  always_comb begin
    // NOTE: every signal gets a default at the top of a combinational block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    accept    = bus.in_valid && in_ready_q;
    op_mag    = bus.in_data[M-1:0];
    // A zero magnitude is forced positive so that -0 never enters the adder.
    op_sign   = (bus.in_data[WIDTH-1] ^ bus.in_sub) && (op_mag != '0);
    base_sign = (state == IDLE) ? 1'b0 : acc_sign;
    base_mag  = (state == IDLE) ? '0   : acc_mag;
    sum       = {1'b0, base_mag} + {1'b0, op_mag};
    add_sign  = base_sign;
    add_mag   = base_mag;
    clamp     = 1'b0;

    if (base_sign == op_sign) begin
      // Carry out of the magnitude field means the sum exceeds MAX.
      if (sum[M]) begin
        add_mag = '1;
        clamp   = 1'b1;
      end else begin
        add_mag = sum[M-1:0];
      end
    end else if (base_mag >= op_mag) begin
      add_mag  = base_mag - op_mag;
      add_sign = base_sign;
    end else begin
      add_mag  = op_mag - base_mag;
      add_sign = op_sign;
    end

    // Cancellation to zero always yields +0.
    if (add_mag == '0) begin
      add_sign = 1'b0;
    end
  end

  // Next-state and register-update decisions.
  always_comb begin
    state_n    = state;
    acc_sign_n = acc_sign;
    acc_mag_n  = acc_mag;
    sat_n      = sat;
    count_n    = count;

    case (state)
      IDLE, ACC: begin
        if (accept) begin
          acc_sign_n = add_sign;
          acc_mag_n  = add_mag;
          if (state == IDLE) begin
            sat_n   = clamp;
            count_n = COUNT_W'(1);
          end else begin
            sat_n   = sat | clamp;
            // Beat counter holds at all-ones instead of wrapping.
            count_n = (count == '1) ? count : count + COUNT_W'(1);
          end
          state_n = bus.in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Registered ready: low through reset and during HOLD, so there is no
    // same-cycle turnaround from result handoff to the next beat.
    in_ready_n = (state_n != HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc_sign   <= 1'b0;
      acc_mag    <= '0;
      sat        <= 1'b0;
      count      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      acc_sign   <= acc_sign_n;
      acc_mag    <= acc_mag_n;
      sat        <= sat_n;
      count      <= count_n;
      in_ready_q <= in_ready_n;
    end
  end

  // All outputs come straight from registers.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = {acc_sign, acc_mag};
  assign bus.out_sat   = sat;
  assign bus.out_count = count;

endmodule

// File: tb/tb_sm_sat_accum.sv
// Self-checking bench for sm_sat_accum: directed frames from the test plan,
// backpressure, mid-frame reset, a narrow-counter instance, and randomized
// frames checked against an integer-arithmetic reference model.
module tb_sm_sat_accum;

  localparam int WIDTH   = 16;
  localparam int COUNT_W = 8;
  localparam int M       = WIDTH - 1;
  localparam int MAX     = (1 << M) - 1;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_sat_accum_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();
  sm_sat_accum_if #(.WIDTH(WIDTH), .COUNT_W(2))       bus2 ();

  sm_sat_accum #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sm_sat_accum #(.WIDTH(WIDTH), .COUNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q_data[$];
  logic             q_sub[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding of a signed integer into sign-magnitude.
  function automatic logic [WIDTH-1:0] encode(input int v);
    logic [WIDTH-1:0] r;
    if (v < 0) r = {1'b1, M'(-v)};
    else       r = {1'b0, M'(v)};
    return r;
  endfunction

  // Present one beat and wait (bounded) until it is accepted.
  // Called at a time away from the rising edge.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic s, input logic last);
    int waitc;
    waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sub   = 1'b0;
  endtask

  // Send the queued frame, compare against the model, then take the result.
  task automatic run_frame(input string tag, input bit gaps);
    int acc, cnt, n, mag;
    bit sat, sgn;
    logic [WIDTH-1:0] d;
    acc = 0; cnt = 0; sat = 0;
    n = q_data.size();
    for (int i = 0; i < n; i++) begin
      d   = q_data[i];
      mag = int'(d[M-1:0]);
      sgn = d[WIDTH-1] ^ q_sub[i];
      acc = acc + (sgn ? -mag : mag);
      if (acc > MAX) begin
        acc = MAX; sat = 1;
      end else if (acc < -MAX) begin
        acc = -MAX; sat = 1;
      end
      if (cnt < CNT_MAX) cnt++;
    end

    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(q_data[i], q_sub[i], i == n - 1);
    end

    // One cycle after the last beat the result must be presented.
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, ".out_data"},  32'(bus.out_data),  32'(encode(acc)));
    check({tag, ".out_sat"},   32'(bus.out_sat),   32'(sat));
    check({tag, ".out_count"}, 32'(bus.out_count), 32'(cnt));

    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(bus.in_ready),  32'd1);
    q_data.delete();
    q_sub.delete();
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic s);
    q_data.push_back(d);
    q_sub.push_back(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] held_data;
    logic [COUNT_W-1:0] held_count;
    int n;

    bus.in_valid = 0; bus.in_data = '0; bus.in_sub = 0; bus.in_last = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_sub = 0; bus2.in_last = 0; bus2.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.in_ready",  32'(bus.in_ready),  32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_data",  32'(bus.out_data),  32'd0);
    check("rst.out_sat",   32'(bus.out_sat),   32'd0);
    check("rst.out_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Single beat, 1-cycle latency
    push(16'h0005, 0);
    run_frame("single", 0);

    // Positive overflow
    push(16'h7FF0, 0); push(16'h0020, 0);
    run_frame("pos_ovf", 0);

    // Cancellation and subtraction
    push(16'h8005, 0); push(16'h0005, 0);
    run_frame("cancel", 0);
    push(16'h0003, 0); push(16'h0003, 1);
    run_frame("sub_zero", 0);
    push(16'h0002, 0); push(16'h0007, 1);
    run_frame("sub_neg", 0);

    // Recovery after clamp, then negative overflow
    push(16'h7FFF, 0); push(16'h7FFF, 0); push(16'h8001, 0);
    run_frame("recover", 0);
    push(16'hFFF0, 0); push(16'h8020, 0);
    run_frame("neg_ovf", 0);

    // Negative zero operand is +0
    push(16'h8000, 0); push(16'h0000, 1);
    run_frame("neg_zero", 0);

    // Backpressure: result held, next beat waits
    send_beat(16'h0004, 0, 1);
    held_data  = bus.out_data;
    held_count = bus.out_count;
    check("bp.value", 32'(held_data), 32'h0004);
    bus.in_valid = 1'b1; bus.in_data = 16'h0009; bus.in_sub = 0; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.out_data",  32'(bus.out_data),  32'(held_data));
      check("bp.out_count", 32'(bus.out_count), 32'(held_count));
      check("bp.in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp.idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("bp.next_valid", 32'(bus.out_valid), 32'd1);
    check("bp.next_data",  32'(bus.out_data),  32'h0009);
    check("bp.next_count", 32'(bus.out_count), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset mid-frame, asserted between edges
    send_beat(16'h0010, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.out_data",  32'(bus.out_data),  32'd0);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.in_ready",  32'(bus.in_ready),  32'd0);
    check("midrst.out_count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(16'h0001, 0);
    run_frame("after_rst", 0);

    // Narrow counter saturates at 3 after 5 beats
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_data = 16'h0001; bus2.in_last = (i == 4);
      check("small.in_ready", 32'(bus2.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    check("small.out_valid", 32'(bus2.out_valid), 32'd1);
    check("small.out_data",  32'(bus2.out_data),  32'h0005);
    check("small.out_count", 32'(bus2.out_count), 32'd3);
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b0;

    // Randomized frames with stalls
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       push({1'($urandom), 15'($urandom_range(MAX - 64, MAX))}, 1'($urandom));
          1:       push({1'($urandom), 15'($urandom_range(0, 3))}, 1'($urandom));
          default: push(16'($urandom), 1'($urandom));
        endcase
      end
      run_frame("random", 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
